// File: rtl/bus_arbiter.sv
// ============================================================================
// Module  : bus_arbiter
// Brief   : Shared-bus arbiter with one-hot registered grant and idle
//           turnaround between tenures. Define BUS_ARB_ROUND_ROBIN_EN for
//           round-robin selection; the default build is fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] bus_req,
  output logic [NUM_MASTERS-1:0] bus_grant,
  output logic [IDX_W-1:0]       owner,
  output logic                   owner_valid,
  output logic                   bus_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  localparam logic [1:0]       C_TURN_LOAD = 2'(TURN_CYCLES);
  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NUM_MASTERS - 1);

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]       r_owner, w_owner_nxt;
  logic [1:0]             r_cnt,   w_cnt_nxt;
  logic                   w_any;
  logic [IDX_W-1:0]       w_win;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  localparam logic [IDX_W:0] C_NUM = (IDX_W+1)'(NUM_MASTERS);

  logic [IDX_W-1:0]         r_ptr, w_ptr_nxt;
  logic [2*NUM_MASTERS-1:0] w_dbl;
  logic [NUM_MASTERS-1:0]   w_rot;
  logic [IDX_W-1:0]         w_off;
  logic [IDX_W:0]           w_sum;

  // Rotate requests so the pointer position sits at bit 0, pick the lowest
  // set bit, then map the offset back to an absolute index.
  always_comb begin
    w_dbl = {bus_req, bus_req} >> r_ptr;
    w_rot = w_dbl[NUM_MASTERS-1:0];
    w_off = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= C_NUM) w_sum = w_sum - C_NUM;
    w_win = w_sum[IDX_W-1:0];
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus_req[i]) w_win = IDX_W'(i);
    end
  end
`endif

  assign w_any = |bus_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      r_ptr   <= w_ptr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
          w_owner_nxt        = w_win;
          w_state_nxt        = S_GRANT;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          w_ptr_nxt = (w_win == C_LAST_IDX) ? '0 : w_win + 1'b1;
`endif
        end
      end
      S_GRANT: begin
        // No preemption: only the owner releasing its request ends the tenure.
        if (!bus_req[r_owner]) begin
          w_grant_nxt = '0;
          w_owner_nxt = '0;
          if (TURN_CYCLES > 0) begin
            w_cnt_nxt   = C_TURN_LOAD;
            w_state_nxt = S_TURN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_TURN: begin
        if (r_cnt <= 2'd1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_owner_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus_grant   = r_grant;
  assign owner       = r_owner;
  assign owner_valid = |r_grant;
  assign bus_busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter for the shared system bus (addr/data/rd/wr/data_mask/fc tri-state lines).
- Takes a bus_req line from each bus master (CPU, DMA channels, future masters) and returns one registered, one-hot bus_grant.
- A master drives the bus only while its grant is high.
- A programmable idle turnaround separates consecutive tenures so tri-state drivers never overlap.

Parameters:
- NUM_MASTERS, 4, number of requesters; legal range 2..8; index 0 is the CPU.
- IDX_W, 2, width of owner index; must equal clog2(NUM_MASTERS), minimum 1.
- TURN_CYCLES, 1, idle cycles inserted after a grant drops before the next grant may assert; legal range 0..3.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- bus_req  input  NUM_MASTERS  request per master; level-held for the whole tenure.
- bus_grant  output  NUM_MASTERS  registered one-hot grant; all zeros when the bus is free.
- owner  output  IDX_W  index of the granted master; 0 when no grant.
- owner_valid  output  1  high iff any bus_grant bit is high.
- bus_busy  output  1  high in GRANT and TURNAROUND states.

Behaviour:
- Reset (rst=0, asynchronous): bus_grant=0, owner=0, owner_valid=0, bus_busy=0, state=IDLE, turnaround counter=0, round-robin pointer=0.
- Reset mid-tenure drops the grant immediately, without waiting for a clock edge.
- States: IDLE, GRANT, TURNAROUND; encoded as 2 bits.
- IDLE:
  - If any bus_req bit is high at a rising edge, the winner's bus_grant bit goes high at that edge; go to GRANT.
  - Latency from request sampled to grant visible: 1 clock.
  - No requests: remain in IDLE, outputs zero.
- GRANT:
  - Grant holds while bus_req[owner]=1; other requests are ignored, no preemption.
  - When bus_req[owner]=0 is sampled: bus_grant clears at that edge.
  - If TURN_CYCLES>0: load counter with TURN_CYCLES and go to TURNAROUND.
  - If TURN_CYCLES=0: go to IDLE. The next grant can then assert on the following edge, so there is always at least one cycle with no grant.
- TURNAROUND:
  - No grant; counter decrements each edge.
  - When counter reaches 1, go to IDLE at that edge.
  - Requests arriving here are not lost; they are evaluated in IDLE.
- Winner selection (combinational on bus_req, evaluated only in IDLE): policy per Optional Feature.
- Round-robin pointer updates to (winner+1) mod NUM_MASTERS when a grant is issued; wrap-around from NUM_MASTERS-1 to 0.
- A requester that drops bus_req before being granted is simply not selected.
- Glitch-free rule: bus_grant is a flop output; it never changes except at a clock edge or at async reset.
- Invariant: at most one bus_grant bit is high; owner_valid == |bus_grant.

Optional Feature:
- BUS_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration.
  - Search starts at the pointer and proceeds upward with wrap; the first requesting index wins.
  - Guarantees each requester is granted within NUM_MASTERS tenures.
- Undefined:
  - Fixed priority; the lowest requesting index wins (CPU highest).
  - Pointer logic is absent.
  - Starvation of high indices is permitted.

Test Plan:
- Reset: rst=0 while bus_req=4'b1111 -> bus_grant=0, owner_valid=0, bus_busy=0. Release reset -> bus_grant=4'b0001 exactly 1 clock later.
- Single requester, TURN_CYCLES=1: bus_req=4'b0100 at edge 0, dropped at edge 5 -> bus_grant=4'b0100 after edges 0..4, owner=2, zero after edge 5, bus_busy high through edge 6.
- Contention, round-robin: bus_req=4'b1111, each master holds 3 cycles -> grant order 0,1,2,3,0 with exactly TURN_CYCLES+1 grant-free cycles between tenures. Fixed build: order 0,0,0.
- No preemption: master 3 granted, master 0 asserts mid-tenure -> bus_grant stays 4'b1000 until bus_req[3] drops; then master 0 is granted after turnaround.
- Async reset mid-tenure: rst=0 between clock edges while bus_grant=4'b0010 -> bus_grant=0 within the same cycle. After release, round-robin pointer=0 (master 0 wins a tie).
- TURN_CYCLES=0, two masters ping-ponging -> exactly 1 grant-free cycle between tenures; never two grant bits high (assertion over 10k random cycles).
